regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin arbitration; 1 = requester 0 always wins contention.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 (ALU writeback) holds a result.
REQ-005 req0_rd  input  5  requester 0 destination register index.
REQ-006 req0_data  input  32  requester 0 result value.
REQ-007 req0_ready  output  1  requester 0 result accepted this cycle.
REQ-008 req1_valid / req1_rd / req1_data / req1_ready  same as REQ-004..007, for requester 1 (load / multi-cycle unit).
REQ-009 issue_valid  input  1  an instruction with a destination register is issued this cycle.
REQ-010 issue_rd  input  5  destination index of the issued instruction.
REQ-011 wE  output  1  register file write enable, registered.
REQ-012 wR  output  5  register file write index, registered.
REQ-013 wD  output  32  register file write data, registered.
REQ-014 pending  output  32  scoreboard; bit i high = register i has an outstanding write.

Function
REQ-015 A transfer on requester k occurs on a rising edge where reqk_valid and reqk_ready are both high.
REQ-016 reqk_ready is combinational from the valid inputs and the arbiter state; at most one ready is high per cycle.
REQ-017 Only one valid: that requester gets ready=1.
REQ-018 Both valid, FIXED_PRIO=1: req0 gets ready; req1 waits.
REQ-019 Both valid, FIXED_PRIO=0: the requester not recorded in the last_grant register gets ready.
REQ-020 last_grant updates to the index of the requester that transferred, only on a transfer edge; otherwise it holds.
REQ-021 Neither valid: both readies 0 and last_grant holds.
REQ-022 A requester with valid high and ready low keeps rd/data stable until transfer; the arbiter does not check this.
REQ-023 Write latency is one cycle: transfer at edge N gives wE=1, wR=rd, wD=data during cycle N+1; the register file commits at edge N+1.
REQ-024 A transfer with rd=0 is accepted normally and updates last_grant, but wE is 0 in cycle N+1.
REQ-025 With no transfer at edge N, wE=0 in cycle N+1; wR and wD hold their previous values.
REQ-026 Back-to-back transfers on consecutive edges produce consecutive write cycles with no bubble.
REQ-027 Scoreboard set: at an edge with issue_valid=1 and issue_rd!=0, pending[issue_rd] is set.
REQ-028 Scoreboard clear: at an edge where registered wE=1, pending[wR] is cleared (same edge the register file commits).
REQ-029 If a set and a clear hit the same index on one edge, set wins (bit = 1).
REQ-030 pending[0] is constant 0.
REQ-031 Clearing an index whose bit is already 0 is harmless: the bit stays 0 and no error is flagged.

Reset
REQ-032 While rst=1 at an edge: wE=0, wR=0, wD=0, pending=0, last_grant=1 (req0 wins the first contention).
REQ-033 While rst=1, req0_ready and req1_ready are forced to 0, so no transfer occurs.
REQ-034 Reset asserted with a write pending in the output register discards that write; wE=0 in the cycle after the reset edge.
REQ-035 The first transfer is possible at the first edge with rst=0.

Verification
REQ-036 Single write: req0 valid, rd=5, data=0x12345678, one cycle -> req0_ready=1; next cycle wE=1, wR=5, wD=0x12345678; following cycle wE=0.
REQ-037 Contention, FIXED_PRIO=0, after reset: both valid for 4 cycles (rd 1/2) -> grants 0,1,0,1; wR sequence 1,2,1,2 with no bubbles.
REQ-038 Contention, FIXED_PRIO=1: both valid for 3 cycles -> req0_ready=1 and req1_ready=0 each cycle; req1 transfers on the first cycle req0_valid drops.
REQ-039 Scoreboard: issue rd=7 at edge 0 -> pending=0x00000080; req1 transfers rd=7 at edge 3 -> pending=0 after edge 4.
REQ-040 Scoreboard collision: issue rd=9 on the same edge wE=1, wR=9 -> pending[9]=1; issue rd=0 -> pending unchanged.
REQ-041 Reset mid-operation: transfer rd=3 at edge N, rst=1 at edge N+1 -> wE=0 after edge N+1, pending=0, both readies 0 while rst=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with a destination-register scoreboard.
// Two result producers (ALU and load/multi-cycle unit) compete for a single
// register-file write port. The winning result is registered and presented
// to the register file one cycle after the transfer. The pending scoreboard
// tracks registers that have an issued but not yet committed write.

module regfile_wb_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [4:0]  req0_rd,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_rd,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        wE,
    output logic [4:0]  wR,
    output logic [31:0] wD,
    output logic [31:0] pending
);

    // Index of the requester that won the most recent transfer; the other one
    // is favoured on the next contention in round-robin mode.
    logic        last_grant;
    logic        xfer0;
    logic        xfer1;
    logic [31:0] pending_next;

    // Grant decision: a lone requester always wins, contention is resolved by
    // fixed priority or by alternating away from the last winner.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                if (FIXED_PRIO || last_grant) begin
                    req0_ready = 1'b1;
                end else begin
                    req1_ready = 1'b1;
                end
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign xfer0 = req0_valid && req0_ready;
    assign xfer1 = req1_valid && req1_ready;

    // Remember the winner of each transfer; reset favours requester 0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (xfer0) begin
            last_grant <= 1'b0;
        end else if (xfer1) begin
            last_grant <= 1'b1;
        end
    end

    // Capture the accepted result into the write-port register; writes to x0
    // are accepted from the requester but never enabled on the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wE <= 1'b0;
            wR <= 5'd0;
            wD <= 32'd0;
        end else if (xfer0) begin
            wE <= (req0_rd != 5'd0);
            wR <= req0_rd;
            wD <= req0_data;
        end else if (xfer1) begin
            wE <= (req1_rd != 5'd0);
            wR <= req1_rd;
            wD <= req1_data;
        end else begin
            wE <= 1'b0;
        end
    end

    // Scoreboard update: commit clears, issue sets, and a set on the same
    // register as a commit wins because a newer write is now outstanding.
    always_comb begin
        pending_next = pending;
        if (wE) begin
            pending_next[wR] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Two instances share stimulus:
// rr_* is round-robin, fp_* is fixed priority.

module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;

    logic        rr_ready0, rr_ready1, rr_wE;
    logic [4:0]  rr_wR;
    logic [31:0] rr_wD, rr_pending;
    logic        fp_ready0, fp_ready1, fp_wE;
    logic [4:0]  fp_wR;
    logic [31:0] fp_wD, fp_pending;

    int checks;
    int failures;

    regfile_wb_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(rr_ready0),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(rr_ready1),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wE(rr_wE), .wR(rr_wR), .wD(rr_wD), .pending(rr_pending)
    );

    regfile_wb_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(fp_ready0),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(fp_ready1),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wE(fp_wE), .wR(fp_wR), .wD(fp_wD), .pending(fp_pending)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid  = 1'b0;
        req0_rd     = 5'd0;
        req0_data   = 32'd0;
        req1_valid  = 1'b0;
        req1_rd     = 5'd0;
        req1_data   = 32'd0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({rr_ready0, rr_ready1, fp_ready0, fp_ready1} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b expected 0000", {rr_ready0, rr_ready1, fp_ready0, fp_ready1});
        end
        tick();
        tick();
        checks++;
        if ({rr_wE, rr_wR, rr_wD} !== 38'd0) begin
            failures++;
            $display("[TB] FAIL reset_wport: got wE=%b wR=%0d wD=%h expected 0 0 0", rr_wE, rr_wR, rr_wD);
        end
        checks++;
        if (rr_pending !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_pending: got %h expected 00000000", rr_pending);
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        req0_valid = 1'b1;
        req0_rd    = 5'd5;
        req0_data  = 32'h1234_5678;
        #1;
        checks++;
        if ({rr_ready0, rr_ready1} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL single_ready: got %b expected 10", {rr_ready0, rr_ready1});
        end
        tick();
        idle_inputs();
        checks++;
        if (rr_wE !== 1'b1 || rr_wR !== 5'd5 || rr_wD !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL single_write: got wE=%b wR=%0d wD=%h expected 1 5 12345678", rr_wE, rr_wR, rr_wD);
        end
        tick();
        checks++;
        if (rr_wE !== 1'b0 || rr_wR !== 5'd5 || rr_wD !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL single_hold: got wE=%b wR=%0d wD=%h expected 0 5 12345678", rr_wE, rr_wR, rr_wD);
        end
    endtask

    task automatic test_contention_rr();
        logic [4:0] exp_rd;
        test_reset();
        req0_valid = 1'b1;
        req0_rd    = 5'd1;
        req0_data  = 32'hAAAA_0001;
        req1_valid = 1'b1;
        req1_rd    = 5'd2;
        req1_data  = 32'hBBBB_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({rr_ready0, rr_ready1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("[TB] FAIL rr_grant%0d: got %b expected %b", i, {rr_ready0, rr_ready1},
                         ((i % 2 == 0) ? 2'b10 : 2'b01));
            end
            tick();
            exp_rd = (i % 2 == 0) ? 5'd1 : 5'd2;
            checks++;
            if (rr_wE !== 1'b1 || rr_wR !== exp_rd) begin
                failures++;
                $display("[TB] FAIL rr_write%0d: got wE=%b wR=%0d expected 1 %0d", i, rr_wE, rr_wR, exp_rd);
            end
        end
        req1_valid = 1'b0;
        req0_rd    = 5'd0;
        #1;
        checks++;
        if (rr_ready0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rr_x0_ready: got %b expected 1", rr_ready0);
        end
        tick();
        checks++;
        if (rr_wE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rr_x0_noenable: got wE=%b expected 0", rr_wE);
        end
        req0_rd    = 5'd1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({rr_ready0, rr_ready1} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL rr_after_x0: got %b expected 01", {rr_ready0, rr_ready1});
        end
        tick();
        idle_inputs();
        checks++;
        if (rr_wE !== 1'b1 || rr_wR !== 5'd2 || rr_wD !== 32'hBBBB_0002) begin
            failures++;
            $display("[TB] FAIL rr_after_x0_write: got wE=%b wR=%0d wD=%h expected 1 2 bbbb0002", rr_wE, rr_wR, rr_wD);
        end
    endtask

    task automatic test_contention_fixed();
        test_reset();
        req0_valid = 1'b1;
        req0_rd    = 5'd4;
        req0_data  = 32'h0000_0404;
        req1_valid = 1'b1;
        req1_rd    = 5'd6;
        req1_data  = 32'h0000_0606;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({fp_ready0, fp_ready1} !== 2'b10) begin
                failures++;
                $display("[TB] FAIL fp_grant%0d: got %b expected 10", i, {fp_ready0, fp_ready1});
            end
            tick();
        end
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({fp_ready0, fp_ready1} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL fp_req1_turn: got %b expected 01", {fp_ready0, fp_ready1});
        end
        tick();
        idle_inputs();
        checks++;
        if (fp_wE !== 1'b1 || fp_wR !== 5'd6 || fp_wD !== 32'h0000_0606) begin
            failures++;
            $display("[TB] FAIL fp_req1_write: got wE=%b wR=%0d wD=%h expected 1 6 00000606", fp_wE, fp_wR, fp_wD);
        end
    endtask

    task automatic test_scoreboard();
        test_reset();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        idle_inputs();
        checks++;
        if (rr_pending !== 32'h0000_0080) begin
            failures++;
            $display("[TB] FAIL sb_set: got %h expected 00000080", rr_pending);
        end
        tick();
        tick();
        req1_valid = 1'b1;
        req1_rd    = 5'd7;
        req1_data  = 32'hCAFE_0007;
        #1;
        checks++;
        if (rr_ready1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sb_req1_ready: got %b expected 1", rr_ready1);
        end
        tick();
        idle_inputs();
        checks++;
        if (rr_pending !== 32'h0000_0080 || rr_wE !== 1'b1 || rr_wR !== 5'd7) begin
            failures++;
            $display("[TB] FAIL sb_before_commit: got pending=%h wE=%b wR=%0d expected 00000080 1 7", rr_pending, rr_wE, rr_wR);
        end
        tick();
        checks++;
        if (rr_pending !== 32'd0) begin
            failures++;
            $display("[TB] FAIL sb_clear: got %h expected 00000000", rr_pending);
        end
    endtask

    task automatic test_collision();
        test_reset();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        issue_valid = 1'b0;
        req0_valid  = 1'b1;
        req0_rd     = 5'd9;
        req0_data   = 32'h0000_0009;
        tick();
        req0_valid  = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        checks++;
        if (rr_wE !== 1'b1 || rr_wR !== 5'd9) begin
            failures++;
            $display("[TB] FAIL col_wport: got wE=%b wR=%0d expected 1 9", rr_wE, rr_wR);
        end
        tick();
        checks++;
        if (rr_pending !== 32'h0000_0200) begin
            failures++;
            $display("[TB] FAIL col_set_wins: got %h expected 00000200", rr_pending);
        end
        issue_rd = 5'd0;
        tick();
        checks++;
        if (rr_pending !== 32'h0000_0200) begin
            failures++;
            $display("[TB] FAIL col_issue_x0: got %h expected 00000200", rr_pending);
        end
        issue_valid = 1'b0;
        req1_valid  = 1'b1;
        req1_rd     = 5'd12;
        req1_data   = 32'h0000_000C;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (rr_pending !== 32'h0000_0200) begin
            failures++;
            $display("[TB] FAIL col_clear_idle_bit: got %h expected 00000200", rr_pending);
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        issue_valid = 1'b0;
        req0_valid  = 1'b1;
        req0_rd     = 5'd3;
        req0_data   = 32'h0000_0333;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({rr_ready0, rr_ready1} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL mid_ready_in_reset: got %b expected 00", {rr_ready0, rr_ready1});
        end
        tick();
        checks++;
        if (rr_wE !== 1'b0 || rr_pending !== 32'd0) begin
            failures++;
            $display("[TB] FAIL mid_discard: got wE=%b pending=%h expected 0 00000000", rr_wE, rr_pending);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rr_ready0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_first_ready: got %b expected 1", rr_ready0);
        end
        tick();
        idle_inputs();
        checks++;
        if (rr_wE !== 1'b1 || rr_wR !== 5'd3 || rr_wD !== 32'h0000_0333) begin
            failures++;
            $display("[TB] FAIL mid_first_write: got wE=%b wR=%0d wD=%h expected 1 3 00000333", rr_wE, rr_wR, rr_wD);
        end
    endtask

    // Run every scenario in order and report.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_write();
        test_contention_rr();
        test_contention_fixed();
        test_scoreboard();
        test_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
